// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one NAND full-adder cell sequenced over WIDTH cycles, LSB first.
// Optional build macro SERIAL_SUB_EN adds a sub port (a-b via inverted b and carry-in of 1).
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_nx_s;
  logic             accept_s;
  logic             last_s;
  logic [WIDTH-1:0] a_sr_r;
  logic [WIDTH-1:0] b_sr_r;
  logic [WIDTH-1:0] res_sr_r;
  logic [CNT_W-1:0] cnt_r;
  logic             carry_r;
  logic [WIDTH-1:0] b_load_s;
  logic             c_init_s;
  logic [1:0]       fa_s;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;

  // Full adder from two NAND half adders; the carries are ORed in NAND form. Returns {carry, sum}.
  function automatic logic [1:0] fa_nand(input logic x, input logic y, input logic ci);
    logic n1;
    logic h1;
    logic n2;
    logic h2;
    n1 = ~(x & y);
    h1 = ~(~(x & n1) & ~(y & n1));
    n2 = ~(h1 & ci);
    h2 = ~(~(h1 & n2) & ~(ci & n2));
    return {~(n1 & n2), h2};
  endfunction

  // Operand conditioning applied at capture time.
  always_comb begin
    b_load_s = b;
    c_init_s = 1'b0;
`ifdef SERIAL_SUB_EN
    if (sub) begin
      b_load_s = ~b;
      c_init_s = 1'b1;
    end else begin
      b_load_s = b;
      c_init_s = 1'b0;
    end
`endif
  end

  assign fa_s   = fa_nand(a_sr_r[0], b_sr_r[0], carry_r);
  assign last_s = (cnt_r == CNT_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic; start is only honoured in IDLE or DONE.
  always_comb begin
    state_nx_s = state_r;
    accept_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nx_s = ST_LOAD;
          accept_s   = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        state_nx_s = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (last_s) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_nx_s = ST_LOAD;
          accept_s   = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Operand capture, per-bit shifting and result latching.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr_r   <= '0;
      b_sr_r   <= '0;
      res_sr_r <= '0;
      cnt_r    <= '0;
      carry_r  <= 1'b0;
      sum_r    <= '0;
      cout_r   <= 1'b0;
    end else if (accept_s) begin
      a_sr_r  <= a;
      b_sr_r  <= b_load_s;
      carry_r <= c_init_s;
      cnt_r   <= '0;
    end else if (state_r == ST_SHIFT) begin
      a_sr_r   <= a_sr_r >> 1;
      b_sr_r   <= b_sr_r >> 1;
      carry_r  <= fa_s[1];
      res_sr_r <= {fa_s[0], res_sr_r[WIDTH-1:1]};
      cnt_r    <= cnt_r + CNT_W'(1);
      // Published result only changes on the final bit so sum/cout stay stable mid-op.
      if (last_s) begin
        sum_r  <= {fa_s[0], res_sr_r[WIDTH-1:1]};
        cout_r <= fa_s[1];
      end
    end
  end

  // Status flags registered from the next state so they align with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_nx_s == ST_LOAD) || (state_nx_s == ST_SHIFT);
      done_r <= (state_nx_s == ST_DONE);
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign sum  = sum_r;
  assign cout = cout_r;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl (WIDTH=8); subtract cases build with SERIAL_SUB_EN.
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
`ifdef SERIAL_SUB_EN
  logic       sub;
`endif
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef SERIAL_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  // Issue one start pulse and count cycles until done (i=1 is the cycle after the accepting edge).
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic ts,
                        output int lat, output int busy_n, output bit overlap);
    @(negedge clk);
    a = ta;
    b = tb_v;
`ifdef SERIAL_SUB_EN
    sub = ts;
`endif
    start = 1'b1;
    lat = 0;
    busy_n = 0;
    overlap = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy && done) overlap = 1'b1;
      if (busy) busy_n++;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic check_op(input string name, input int lat, input logic [7:0] exp_sum,
                          input logic exp_cout);
    checks++;
    if (lat !== 10) begin
      failures++;
      $display("FAIL %s_latency: got %0d expected 10", name, lat);
    end
    checks++;
    if (sum !== exp_sum) begin
      failures++;
      $display("FAIL %s_sum: got %h expected %h", name, sum, exp_sum);
    end
    checks++;
    if (cout !== exp_cout) begin
      failures++;
      $display("FAIL %s_cout: got %b expected %b", name, cout, exp_cout);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    a = 8'h00;
    b = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, sum, cout} !== 11'b0) begin
      failures++;
      $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b expected all 0",
               busy, done, sum, cout);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++;
      $display("FAIL reset_idle: got busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_basic;
    int lat;
    int bn;
    bit ov;
    run_op(8'h5A, 8'h33, 1'b0, lat, bn, ov);
    check_op("basic", lat, 8'h8D, 1'b0);
    checks++;
    if (bn !== 9) begin
      failures++;
      $display("FAIL basic_busy_cycles: got %0d expected 9", bn);
    end
    checks++;
    if (ov !== 1'b0) begin
      failures++;
      $display("FAIL basic_busy_done_overlap: got %b expected 0", ov);
    end
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++;
      $display("FAIL basic_done_pulse: got busy=%b done=%b expected 0 0", busy, done);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({sum, cout} !== {8'h8D, 1'b0}) begin
      failures++;
      $display("FAIL basic_hold: got %h/%b expected 8d/0", sum, cout);
    end
  endtask

  task automatic test_boundary;
    int lat;
    int bn;
    bit ov;
    run_op(8'hFF, 8'h01, 1'b0, lat, bn, ov);
    check_op("wrap", lat, 8'h00, 1'b1);
    run_op(8'h00, 8'h00, 1'b0, lat, bn, ov);
    check_op("zero", lat, 8'h00, 1'b0);
  endtask

  task automatic test_back_to_back;
    int done_i[3];
    int n = 0;
    int lat = 0;
    @(negedge clk);
    a = 8'h10;
    b = 8'h20;
    start = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (n > 0 && i == done_i[n-1] + 1) begin
        checks++;
        if (busy !== 1'b1) begin
          failures++;
          $display("FAIL b2b_reload: got busy=%b expected 1 after done %0d", busy, n);
        end
      end
      if (n == 3 && i == done_i[2] + 1) break;
      if (done) begin
        checks++;
        if ({sum, cout} !== {8'h30, 1'b0}) begin
          failures++;
          $display("FAIL b2b_result: got %h/%b expected 30/0", sum, cout);
        end
        done_i[n] = i;
        n++;
      end
    end
    start = 1'b0;
    checks++;
    if (n !== 3) begin
      failures++;
      $display("FAIL b2b_count: got %0d expected 3", n);
    end else begin
      checks++;
      if (done_i[0] !== 10 || done_i[1] - done_i[0] !== 10 || done_i[2] - done_i[1] !== 10) begin
        failures++;
        $display("FAIL b2b_spacing: got %0d,%0d,%0d expected 10,20,30",
                 done_i[0], done_i[1], done_i[2]);
      end
    end
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
    end
    checks++;
    if (lat == 0) begin
      failures++;
      $display("FAIL b2b_flush: got no done expected one within 20 cycles");
    end
  endtask

  task automatic test_ignore;
    int lat = 0;
    @(negedge clk);
    a = 8'h5A;
    b = 8'h33;
    start = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (i == 5) begin
        start = 1'b1;
        a = 8'hFF;
        b = 8'hFF;
      end
      if (i == 6) begin
        start = 1'b0;
        a = 8'h01;
        b = 8'h02;
      end
      if (done) begin
        lat = i;
        break;
      end
    end
    check_op("ignore", lat, 8'h8D, 1'b0);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL ignore_not_queued: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    int bn;
    bit ov;
    @(negedge clk);
    a = 8'h12;
    b = 8'h34;
    start = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == 6) rst = 1'b1;
      if (i == 7) rst = 1'b0;
    end
    checks++;
    if ({busy, done, sum, cout} !== 11'b0) begin
      failures++;
      $display("FAIL midreset_outputs: got busy=%b done=%b sum=%h cout=%b expected all 0",
               busy, done, sum, cout);
    end
    repeat (12) @(negedge clk);
    checks++;
    if ({busy, done, sum} !== 10'b0) begin
      failures++;
      $display("FAIL midreset_discarded: got busy=%b done=%b sum=%h expected all 0",
               busy, done, sum);
    end
    run_op(8'h12, 8'h34, 1'b0, lat, bn, ov);
    check_op("after_reset", lat, 8'h46, 1'b0);
  endtask

`ifdef SERIAL_SUB_EN
  task automatic test_sub;
    int lat;
    int bn;
    bit ov;
    run_op(8'h05, 8'h07, 1'b1, lat, bn, ov);
    check_op("sub_borrow", lat, 8'hFE, 1'b0);
    run_op(8'h07, 8'h05, 1'b1, lat, bn, ov);
    check_op("sub_noborrow", lat, 8'h02, 1'b1);
    run_op(8'h5A, 8'h33, 1'b0, lat, bn, ov);
    check_op("sub0_add", lat, 8'h8D, 1'b0);
  endtask
`endif

  initial begin
    rst = 1'b1;
    start = 1'b0;
    a = 8'h00;
    b = 8'h00;
`ifdef SERIAL_SUB_EN
    sub = 1'b0;
`endif
    test_reset();
    test_basic();
    test_boundary();
    test_back_to_back();
    test_ignore();
    test_reset_mid();
`ifdef SERIAL_SUB_EN
    test_sub();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
